// File: rtl/mem_access.sv
// rtl/mem_access.sv - Memory stage: SRAM / memory-mapped UART access FSM with writeback
// Optional feature macro MEM_PROTECT_EN: stores below 16'h4000 are blocked and pulse mem_fault.
module mem_access #(
  parameter int unsigned RAM_WAIT       = 1,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] instructionIn,
  input  logic [15:0] addrIn,
  input  logic [15:0] dataIn,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [15:0] wb_data,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  input  logic [15:0] ram_din,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_ready,
  output logic        uart_rx_ack
`ifdef MEM_PROTECT_EN
  ,
  output logic        mem_fault
`endif
);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, UART_WAIT} state_t;

  localparam logic [2:0] WAIT_C  = 3'(RAM_WAIT);
  localparam logic [2:0] WAIT_M1 = 3'(RAM_WAIT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        stall_q, stall_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [17:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_dout_q, ram_dout_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        rx_ack_q, rx_ack_d;

  logic [4:0]  op;
  logic        is_load, is_store, no_wb, hit_data, hit_stat, prot_hit;

  assign op       = instructionIn[15:11];
  assign is_load  = (op == 5'b10010) || (op == 5'b10011);
  assign is_store = (op == 5'b11010) || (op == 5'b11011);
  // nop, b, beqz, bnez, the bteqz/btnez pair of the I8 group, and jr produce no register result
  assign no_wb    = (op == 5'b00001) || (op == 5'b00010) || (op == 5'b00100) ||
                    (op == 5'b00101) ||
                    ((op == 5'b01100) && (instructionIn[10:8] inside {3'b000, 3'b001})) ||
                    ((op == 5'b11101) && (instructionIn[7:0] == 8'h00));
  assign hit_data = (addrIn == UART_DATA_ADDR);
  assign hit_stat = (addrIn == UART_STAT_ADDR);

`ifdef MEM_PROTECT_EN
  logic fault_q;
  assign prot_hit = (addrIn < 16'h4000);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_q == IDLE) && valid_in && is_store && prot_hit && !hit_data && !hit_stat;
    end
  end
  assign mem_fault = fault_q;
`else
  assign prot_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      stall_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= 16'h0000;
      ram_addr_q <= 18'h00000;
      ram_dout_q <= 16'h0000;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      rx_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rx_ack_q   <= rx_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_d    = stall_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_data_d  = wb_data_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rx_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (is_load && hit_data) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            wb_data_d  = {8'h00, uart_rx_data};
            rx_ack_d   = uart_rx_ready;
          end else if (is_load && hit_stat) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            wb_data_d  = {14'b0, uart_rx_ready, ~uart_tx_busy};
          end else if (is_load) begin
            state_d    = RD;
            cnt_d      = 3'd0;
            stall_d    = 1'b1;
            ram_addr_d = {2'b00, addrIn};
            ce_n_d     = 1'b0;
            oe_n_d     = 1'b0;
          end else if (is_store && hit_data) begin
            tx_data_d = dataIn[7:0];
            if (uart_tx_busy) begin
              state_d = UART_WAIT;
              stall_d = 1'b1;
            end else begin
              tx_start_d = 1'b1;
              wb_valid_d = 1'b1;
            end
          end else if (is_store && (hit_stat || prot_hit)) begin
            wb_valid_d = 1'b1;
          end else if (is_store) begin
            state_d    = WR_SETUP;
            stall_d    = 1'b1;
            ram_addr_d = {2'b00, addrIn};
            ram_dout_d = dataIn;
            ce_n_d     = 1'b0;
            we_n_d     = 1'b1;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = ~no_wb;
            wb_data_d  = addrIn;
          end
        end
      end
      // Read data is captured as the strobes release; the writeback pulse follows one cycle later.
      RD: begin
        if (cnt_q == WAIT_C) begin
          state_d    = IDLE;
          stall_d    = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b1;
        end else if (cnt_q == WAIT_M1) begin
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          wb_data_d = ram_din;
          cnt_d     = WAIT_C;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = 3'd0;
      end
      WR_PULSE: begin
        if (cnt_q == WAIT_M1) begin
          state_d = WR_HOLD;
          we_n_d  = 1'b1;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      // First cycle keeps ce_n low for address/data hold, second cycle is the completion beat.
      WR_HOLD: begin
        if (cnt_q == 3'd0) begin
          ce_n_d = 1'b1;
          cnt_d  = 3'd1;
        end else begin
          state_d    = IDLE;
          stall_d    = 1'b0;
          wb_valid_d = 1'b1;
        end
      end
      UART_WAIT: begin
        if (!uart_tx_busy) begin
          state_d    = IDLE;
          stall_d    = 1'b0;
          tx_start_d = 1'b1;
          wb_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        stall_d = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
      end
    endcase
  end

  assign stall         = stall_q;
  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_data       = wb_data_q;
  assign ram_addr      = ram_addr_q;
  assign ram_dout      = ram_dout_q;
  assign ram_ce_n      = ce_n_q;
  assign ram_oe_n      = oe_n_q;
  assign ram_we_n      = we_n_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = tx_start_q;
  assign uart_rx_ack   = rx_ack_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - Directed, table-driven bench for mem_access (RAM_WAIT=1 and RAM_WAIT=2 instances)
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] instructionIn = 16'h0000;
  logic [15:0] addrIn = 16'h0000;
  logic [15:0] dataIn = 16'h0000;
  logic [15:0] ram_din = 16'h0000;
  logic        uart_tx_busy = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_ready = 1'b0;

  logic        a_stall, a_wbv, a_wbwe, a_ce_n, a_oe_n, a_we_n, a_tx_start, a_rx_ack;
  logic [15:0] a_wbdata, a_dout;
  logic [17:0] a_addr;
  logic [7:0]  a_tx_data;
  logic        b_stall, b_wbv, b_wbwe, b_ce_n, b_oe_n, b_we_n, b_tx_start, b_rx_ack;
  logic [15:0] b_wbdata, b_dout;
  logic [17:0] b_addr;
  logic [7:0]  b_tx_data;
`ifdef MEM_PROTECT_EN
  logic        a_fault, b_fault;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access #(.RAM_WAIT(1)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instructionIn(instructionIn),
    .addrIn(addrIn), .dataIn(dataIn), .stall(a_stall), .wb_valid(a_wbv),
    .wb_we(a_wbwe), .wb_data(a_wbdata), .ram_addr(a_addr), .ram_dout(a_dout),
    .ram_din(ram_din), .ram_ce_n(a_ce_n), .ram_oe_n(a_oe_n), .ram_we_n(a_we_n),
    .uart_tx_data(a_tx_data), .uart_tx_start(a_tx_start), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready), .uart_rx_ack(a_rx_ack)
`ifdef MEM_PROTECT_EN
    , .mem_fault(a_fault)
`endif
  );

  mem_access #(.RAM_WAIT(2)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instructionIn(instructionIn),
    .addrIn(addrIn), .dataIn(dataIn), .stall(b_stall), .wb_valid(b_wbv),
    .wb_we(b_wbwe), .wb_data(b_wbdata), .ram_addr(b_addr), .ram_dout(b_dout),
    .ram_din(ram_din), .ram_ce_n(b_ce_n), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n),
    .uart_tx_data(b_tx_data), .uart_tx_start(b_tx_start), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready), .uart_rx_ack(b_rx_ack)
`ifdef MEM_PROTECT_EN
    , .mem_fault(b_fault)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_busy;
    logic        exp_we;
    logic        chk_data;
    logic [15:0] exp_data;
    logic        exp_ack;
    logic        exp_start;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int we_lo, ce_lo, bad, first_v, nv, st_hi, starts, start_k;
    logic v_we;
    logic [7:0] start_data;

    //               ins       addr      data      rxd    rdy   busy  we    chkd  exp_data  ack   start tx
    vecs[0]  = '{16'h4800, 16'h1234, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{16'h0800, 16'h5555, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{16'h1000, 16'h0100, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{16'h2000, 16'h0200, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{16'h2800, 16'h0300, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{16'hE800, 16'h0400, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{16'hE811, 16'hA5A5, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{16'h9800, 16'hBF01, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{16'h9000, 16'hBF01, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{16'h9800, 16'hBF00, 16'h0000, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, 16'h007E, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{16'h9800, 16'hBF00, 16'h0000, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{16'hD800, 16'hBF00, 16'h0041, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h41};
    vecs[12] = '{16'hD000, 16'hBF01, 16'h1233, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", a_stall, 0);
    chk("rst_wbv", a_wbv, 0);
    chk("rst_wbwe", a_wbwe, 0);
    chk("rst_wbdata", a_wbdata, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
    chk("rst_uart", {a_tx_data, a_tx_start, a_rx_ack}, 10'h000);
    @(negedge clk);
    rst = 1'b1;

    // single-cycle accesses, applied back-to-back
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      valid_in      = 1'b1;
      instructionIn = vecs[i].ins;
      addrIn        = vecs[i].addr;
      dataIn        = vecs[i].data;
      uart_rx_data  = vecs[i].rx_data;
      uart_rx_ready = vecs[i].rx_ready;
      uart_tx_busy  = vecs[i].tx_busy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wbv", i), a_wbv, 1);
      chk($sformatf("v%0d_stall", i), a_stall, 0);
      chk($sformatf("v%0d_we", i), a_wbwe, vecs[i].exp_we);
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), a_wbdata, vecs[i].exp_data);
      chk($sformatf("v%0d_ack", i), a_rx_ack, vecs[i].exp_ack);
      chk($sformatf("v%0d_start", i), a_tx_start, vecs[i].exp_start);
      if (vecs[i].exp_start) chk($sformatf("v%0d_txdata", i), a_tx_data, vecs[i].exp_tx);
    end
    @(negedge clk);
    valid_in = 1'b0;
    uart_rx_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_wbv_drop", a_wbv, 0);
    chk("pulse_start_drop", a_tx_start, 0);

    // SRAM read, RAM_WAIT=1
    @(negedge clk);
    ram_din = 16'hBEEF; instructionIn = 16'h9800; addrIn = 16'h8000; valid_in = 1'b1;
    @(posedge clk);
    #1;
    chk("rd_addr", a_addr, 18'h08000);
    chk("rd_oe_e0", a_oe_n, 0);
    chk("rd_ce_e0", a_ce_n, 0);
    chk("rd_stall_e0", a_stall, 1);
    chk("rd_wbv_e0", a_wbv, 0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("rd_oe_e1", a_oe_n, 1);
    chk("rd_wbv_e1", a_wbv, 0);
    chk("rd_stall_e1", a_stall, 1);
    @(posedge clk);
    #1;
    chk("rd_wbv_e2", a_wbv, 1);
    chk("rd_data_e2", a_wbdata, 16'hBEEF);
    chk("rd_we_e2", a_wbwe, 1);
    chk("rd_stall_e2", a_stall, 0);
    @(posedge clk);
    #1;
    chk("rd_wbv_e3", a_wbv, 0);
    repeat (4) @(posedge clk);

    // SRAM write, RAM_WAIT=2
    @(negedge clk);
    instructionIn = 16'hD800; addrIn = 16'h8001; dataIn = 16'h5A5A; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    we_lo = 0; ce_lo = 0; bad = 0; first_v = -1; nv = 0; v_we = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (b_we_n == 1'b0) we_lo++;
      if (b_ce_n == 1'b0) ce_lo++;
      if (k <= 4 && (b_addr !== 18'h08001 || b_dout !== 16'h5A5A)) bad++;
      if (b_wbv) begin
        nv++;
        if (first_v < 0) begin
          first_v = k;
          v_we = b_wbwe;
        end
      end
    end
    chk("wr_we_low_cycles", we_lo, 2);
    chk("wr_ce_low_cycles", ce_lo, 4);
    chk("wr_addr_data_stable", bad, 0);
    chk("wr_wbv_edge", first_v, 5);
    chk("wr_wbv_count", nv, 1);
    chk("wr_wb_we", v_we, 0);

    // UART transmit while busy for 3 sampled cycles; valid_in during stall must be ignored
    @(negedge clk);
    uart_tx_busy = 1'b1; instructionIn = 16'hD800; addrIn = 16'hBF00; dataIn = 16'h0041; valid_in = 1'b1;
    @(posedge clk);
    #1;
    instructionIn = 16'h4800; addrIn = 16'h7777;
    st_hi = 0; starts = 0; start_k = -1; start_data = 8'h00; nv = 0; v_we = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 2) begin
        valid_in = 1'b0;
        uart_tx_busy = 1'b0;
      end
      if (a_stall) st_hi++;
      if (a_tx_start) begin
        starts++;
        start_k = k;
        start_data = a_tx_data;
      end
      if (a_wbv) begin
        nv++;
        v_we = a_wbwe;
      end
    end
    chk("utx_stall_cycles", st_hi, 3);
    chk("utx_start_count", starts, 1);
    chk("utx_start_edge", start_k, 3);
    chk("utx_data", start_data, 8'h41);
    chk("utx_wbv_count", nv, 1);
    chk("utx_wb_we", v_we, 0);

    // top of address space stays in SRAM
    @(negedge clk);
    instructionIn = 16'h9800; addrIn = 16'hFFFF; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("ffff_addr", a_addr, 18'h0FFFF);
    chk("ffff_oe", a_oe_n, 0);
    repeat (5) @(posedge clk);

    // asynchronous reset during write pulse
    @(negedge clk);
    instructionIn = 16'hD800; addrIn = 16'h8001; dataIn = 16'h1111; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_pre_we", b_we_n, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", b_we_n, 1);
    chk("arst_ce", b_ce_n, 1);
    chk("arst_stall", b_stall, 0);
    chk("arst_wbv", b_wbv, 0);
    @(negedge clk);
    rst = 1'b1;

    // still operational after reset
    @(negedge clk);
    instructionIn = 16'h4800; addrIn = 16'h0F0F; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("post_rst_wbv", b_wbv, 1);
    chk("post_rst_data", b_wbdata, 16'h0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
